menu_level_select: RTL and testbench
====================================

# menu_level_select

Level-select controller for the title menu. It turns the mouse position and left button into the three button-hover flags that the menu renderer uses for highlighting. It also confirms a level choice with a press-and-release click, runs a frame-timed fade-out, and then issues a one-cycle game start. It tracks which levels are unlocked and returns to the menu when the game exits. It sits between the mouse interface and both the menu renderer and the game scene logic.

## Interface
- FADE_STEP_FRAMES, 2: frame ticks per fade increment (1..15).
- INIT_UNLOCK, 3'b001: unlocked-level mask loaded at reset (bit k-1 = level k).
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- frame_tick  in  1  one-cycle pulse once per VGA frame.
- mouse_x  in  10  cursor column, 0..639.
- mouse_y  in  10  cursor row, 0..479.
- mouse_left  in  1  left button level, already synchronized to clk.
- level_clear  in  1  one-cycle pulse: the level in level_clear_id was cleared.
- level_clear_id  in  2  cleared level, 1..3; 0 is ignored.
- game_exit  in  1  one-cycle pulse: leave the game and return to the menu.
- mouseInLevel1/2/3  out  1 each  hover flags for buttons 1..3.
- level_unlocked  out  3  unlocked mask.
- level_sel  out  2  chosen level 1..3; 0 means none chosen.
- start  out  1  one-cycle pulse that launches the game.
- scene  out  2  0 menu, 1 fading, 2 game.
- fade  out  4  darkening level for the renderer, 0..15.

## Operation
- Button regions are inclusive-low and exclusive-high, all with x in [160,480):
  - button 1: y in [80,140).
  - button 2: y in [200,260).
  - button 3: y in [320,380).
- hit_k means the cursor is inside region k and level_unlocked[k-1] = 1.
- mouseInLevelk = hit_k, registered. All three flags are forced to 0 in states CONFIRM, START and PLAY.
- Button edges are detected against a registered copy of mouse_left.
- State MENU (scene 0, fade 0):
  - A rising edge while hit_k holds goes to ARMED and latches arm_id = k.
  - A rising edge outside every region, or over a locked button, is ignored.
- State ARMED (scene 0):
  - On a falling edge with the cursor still in region arm_id, set level_sel = arm_id, clear the fade counters, and go to CONFIRM.
  - On a falling edge anywhere else, go back to MENU with level_sel unchanged.
  - Moving the cursor while the button is held does not cancel the click; only the release position decides.
- State CONFIRM (scene 1):
  - A frame-tick counter counts to FADE_STEP_FRAMES, then fade increments and the counter clears.
  - If fade is already 15 when the step completes, go to START instead of incrementing.
  - Mouse input is ignored.
- State START (scene 1, fade 15): assert start for exactly one cycle, then go to PLAY.
- State PLAY (scene 2, fade 0):
  - On game_exit, go to MENU, set level_sel = 0, and clear the fade counters.
- Unlock rule, applied in every state:
  - level_clear with id 1 sets bit 1; id 2 sets bit 2.
  - id 3 and id 0 change nothing.
  - Bits are never cleared except by reset.
- Simultaneous events:
  - level_clear and game_exit in the same cycle both take effect.
  - An unlock in the same cycle as a rising edge uses the old mask.
- Reset:
  - State goes to MENU.
  - level_sel = 0, start = 0, scene = 0, fade = 0.
  - mouseInLevel1/2/3 = 0.
  - level_unlocked = INIT_UNLOCK.
  - arm_id and both counters go to 0.
  - Reset takes priority over every input and aborts any fade or game in progress.

## Timing
- The hover flags appear 1 cycle after the mouse position they reflect.
- The state change follows the cycle in which the button edge is seen: the edge register adds 1 cycle, so the new state is visible 2 cycles after mouse_left changes.
- Fade length from entering CONFIRM to the start pulse:
  - 16 × FADE_STEP_FRAMES frame ticks, plus 1 cycle.
  - This is 32 ticks at the default setting.
- start is high for exactly the single START cycle.
- scene becomes 2 on the cycle after start.
- level_unlocked updates 1 cycle after level_clear.
- All outputs are registered.

## Test plan
- Reset, cursor at (200,100), pulse button 1 → 1 cycle later mouseInLevel1 = 1. Move cursor to (200,220) → mouseInLevel2 = 0 because level 2 is locked.
- Press at (300,110), release at (300,120) → level_sel = 1 and scene = 1. After 32 frame ticks, start pulses exactly once and scene = 2.
- Press at (300,110), drag to (300,300), release → state returns to MENU, level_sel = 0, start never asserts.
- level_clear with id 1 while in PLAY → level_unlocked = 3'b011. Assert game_exit in the same cycle → scene = 0 and level_sel = 0.
- Press and release on button 2 at (170,210) after the unlock → level_sel = 2. Assert rst at fade = 7 → all outputs return to their reset values and level_unlocked = 3'b001.

Source files
------------

// File: rtl/menu_level_select.sv
// rtl/menu_level_select.sv - title-menu level select: hover flags, click confirm, fade-out, game start
module menu_level_select #(
    parameter int         FADE_STEP_FRAMES = 2,
    parameter logic [2:0] INIT_UNLOCK      = 3'b001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       mouse_left,
    input  logic       level_clear,
    input  logic [1:0] level_clear_id,
    input  logic       game_exit,
    output logic       mouseInLevel1,
    output logic       mouseInLevel2,
    output logic       mouseInLevel3,
    output logic [2:0] level_unlocked,
    output logic [1:0] level_sel,
    output logic       start,
    output logic [1:0] scene,
    output logic [3:0] fade
);

    typedef enum logic [2:0] {
        S_MENU,
        S_ARMED,
        S_CONFIRM,
        S_START,
        S_PLAY
    } state_t;

    localparam logic [3:0] STEP = 4'(FADE_STEP_FRAMES);

    state_t     state_q, state_d;
    logic       ml_q, ml_prev_q;
    logic [1:0] arm_id_q, arm_id_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fade_q, fade_d;
    logic [2:0] unlock_q, unlock_d;
    logic [2:0] hover_q, hover_d;
    logic       start_q, start_d;
    logic [1:0] scene_q, scene_d;

    logic       in_x;
    logic [2:0] in_r;
    logic [2:0] hit;
    logic       rise, fall;
    logic       arm_in;
    logic [2:0] unlock_set;

    // Region decode, edge detect on the registered button copy, unlock bits
    always_comb begin
        in_x    = (mouse_x >= 10'd160) && (mouse_x < 10'd480);
        in_r[0] = in_x && (mouse_y >= 10'd80)  && (mouse_y < 10'd140);
        in_r[1] = in_x && (mouse_y >= 10'd200) && (mouse_y < 10'd260);
        in_r[2] = in_x && (mouse_y >= 10'd320) && (mouse_y < 10'd380);
        // Hover and arming see the mask before any same-cycle unlock
        hit     = in_r & unlock_q;
        rise    = ml_q & ~ml_prev_q;
        fall    = ~ml_q & ml_prev_q;
        arm_in  = ((arm_id_q == 2'd1) && in_r[0]) ||
                  ((arm_id_q == 2'd2) && in_r[1]) ||
                  ((arm_id_q == 2'd3) && in_r[2]);
        unlock_set = 3'b000;
        if (level_clear) begin
            if (level_clear_id == 2'd1) unlock_set = 3'b010;
            if (level_clear_id == 2'd2) unlock_set = 3'b100;
        end
    end

    // Next-state, counters and registered output values
    always_comb begin
        state_d  = state_q;
        arm_id_d = arm_id_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        fade_d   = fade_q;
        unlock_d = unlock_q | unlock_set;
        case (state_q)
            S_MENU: begin
                if (rise && (hit != 3'b000)) begin
                    state_d = S_ARMED;
                    if (hit[0])      arm_id_d = 2'd1;
                    else if (hit[1]) arm_id_d = 2'd2;
                    else             arm_id_d = 2'd3;
                end
            end
            S_ARMED: begin
                // Only the release position matters; dragging while held is allowed
                if (fall) begin
                    if (arm_in) begin
                        sel_d   = arm_id_q;
                        cnt_d   = 4'd0;
                        fade_d  = 4'd0;
                        state_d = S_CONFIRM;
                    end else begin
                        state_d = S_MENU;
                    end
                end
            end
            S_CONFIRM: begin
                if (frame_tick) begin
                    if (4'(cnt_q + 4'd1) == STEP) begin
                        cnt_d = 4'd0;
                        if (fade_q == 4'd15) state_d = S_START;
                        else                 fade_d  = 4'(fade_q + 4'd1);
                    end else begin
                        cnt_d = 4'(cnt_q + 4'd1);
                    end
                end
            end
            S_START: begin
                state_d = S_PLAY;
                fade_d  = 4'd0;
            end
            S_PLAY: begin
                if (game_exit) begin
                    state_d = S_MENU;
                    sel_d   = 2'd0;
                    cnt_d   = 4'd0;
                    fade_d  = 4'd0;
                end
            end
            default: state_d = S_MENU;
        endcase

        start_d = (state_d == S_START);
        case (state_d)
            S_CONFIRM, S_START: scene_d = 2'd1;
            S_PLAY:             scene_d = 2'd2;
            default:            scene_d = 2'd0;
        endcase
        // Hover highlight only while the menu is interactive
        hover_d = ((state_d == S_MENU) || (state_d == S_ARMED)) ? hit : 3'b000;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_MENU;
            ml_q      <= 1'b0;
            ml_prev_q <= 1'b0;
            arm_id_q  <= 2'd0;
            sel_q     <= 2'd0;
            cnt_q     <= 4'd0;
            fade_q    <= 4'd0;
            unlock_q  <= INIT_UNLOCK;
            hover_q   <= 3'b000;
            start_q   <= 1'b0;
            scene_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            ml_q      <= mouse_left;
            ml_prev_q <= ml_q;
            arm_id_q  <= arm_id_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            fade_q    <= fade_d;
            unlock_q  <= unlock_d;
            hover_q   <= hover_d;
            start_q   <= start_d;
            scene_q   <= scene_d;
        end
    end

    assign mouseInLevel1  = hover_q[0];
    assign mouseInLevel2  = hover_q[1];
    assign mouseInLevel3  = hover_q[2];
    assign level_unlocked = unlock_q;
    assign level_sel      = sel_q;
    assign start          = start_q;
    assign scene          = scene_q;
    assign fade           = fade_q;

endmodule

// File: tb/tb_menu_level_select.sv
// tb/tb_menu_level_select.sv - scoreboard bench for menu_level_select
module tb_menu_level_select;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [9:0] mouse_x, mouse_y;
    logic       mouse_left;
    logic       level_clear;
    logic [1:0] level_clear_id;
    logic       game_exit;
    logic       mouseInLevel1, mouseInLevel2, mouseInLevel3;
    logic [2:0] level_unlocked;
    logic [1:0] level_sel;
    logic       start;
    logic [1:0] scene;
    logic [3:0] fade;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [14:0] sb_q[$];

    // Model of the expected outputs, updated by hand in the stimulus
    logic [2:0] m_h   = 3'b000;
    logic [2:0] m_unl = 3'b001;
    logic [1:0] m_sel = 2'd0;
    logic       m_st  = 1'b0;
    logic [1:0] m_sc  = 2'd0;
    logic [3:0] m_fd  = 4'd0;

    menu_level_select #(.FADE_STEP_FRAMES(2), .INIT_UNLOCK(3'b001)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
        .level_clear(level_clear), .level_clear_id(level_clear_id),
        .game_exit(game_exit),
        .mouseInLevel1(mouseInLevel1), .mouseInLevel2(mouseInLevel2),
        .mouseInLevel3(mouseInLevel3), .level_unlocked(level_unlocked),
        .level_sel(level_sel), .start(start), .scene(scene), .fade(fade)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] cur_tuple();
        return {mouseInLevel3, mouseInLevel2, mouseInLevel1, level_unlocked,
                level_sel, start, scene, fade};
    endfunction

    task automatic push_model();
        sb_q.push_back({m_h, m_unl, m_sel, m_st, m_sc, m_fd});
    endtask

    // Monitor: every change of the output tuple must match the next expected entry
    initial begin
        logic [14:0] prev, cur, exp_t;
        bit prev_valid;
        prev_valid = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = cur_tuple();
                if (!prev_valid) begin
                    prev_valid = 1'b1;
                end else if (cur !== prev) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: got %h, required no change from %h", cur, prev);
                    end else begin
                        exp_t = sb_q.pop_front();
                        if (cur !== exp_t) begin
                            errors++;
                            $display("FAIL output_tuple: got %h, required %h", cur, exp_t);
                        end
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d expected changes pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        step(3);
    endtask

    task automatic set_pos(input int x, input int y, input logic [2:0] h);
        mouse_x = 10'(x);
        mouse_y = 10'(y);
        if (h !== m_h) begin
            m_h = h;
            push_model();
        end
        step(1);
        wait_drain("hover");
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
    endtask

    task automatic click(input int hold);
        mouse_left = 1'b1;
        step(hold);
        mouse_left = 1'b0;
        step(hold);
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        mouse_x = '0;
        mouse_y = '0;
        mouse_left = 1'b0;
        level_clear = 1'b0;
        level_clear_id = 2'd0;
        game_exit = 1'b0;
        step(3);
        @(negedge clk);
        checks++;
        if (cur_tuple() !== 15'b000_001_00_0_00_0000) begin
            errors++;
            $display("FAIL reset_state: got %h, required %h", cur_tuple(), 15'b000_001_00_0_00_0000);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Hover regions and edges, locked buttons
        set_pos(200, 100, 3'b001);
        set_pos(200, 220, 3'b000);
        set_pos(160, 80,  3'b001);
        set_pos(159, 80,  3'b000);
        set_pos(479, 139, 3'b001);
        set_pos(480, 139, 3'b000);
        set_pos(479, 140, 3'b000);
        set_pos(300, 379, 3'b000);

        // Click on a locked button is ignored
        set_pos(200, 220, 3'b000);
        click(4);
        wait_drain("locked_click");

        // Press on button 1, drag off, release: back to menu, nothing chosen
        set_pos(300, 110, 3'b001);
        mouse_left = 1'b1;
        step(4);
        set_pos(300, 300, 3'b000);
        mouse_left = 1'b0;
        step(4);
        wait_drain("drag_cancel");

        // Press and release on button 1: confirm
        set_pos(300, 110, 3'b001);
        mouse_left = 1'b1;
        step(4);
        set_pos(300, 120, 3'b001);
        mouse_left = 1'b0;
        m_h = 3'b000; m_sel = 2'd1; m_sc = 2'd1;
        push_model();
        step(4);
        wait_drain("confirm1");

        // Mouse is ignored while fading
        mouse_x = 10'd200;
        mouse_y = 10'd100;
        click(4);
        wait_drain("fade_mouse_ignored");

        // Fade: one step every 2 ticks, start after the 32nd tick
        for (int t = 1; t <= 32; t++) begin
            if ((t % 2 == 0) && t <= 30) begin
                m_fd = 4'(t / 2);
                push_model();
            end
            if (t == 32) begin
                m_st = 1'b1;
                push_model();
                m_st = 1'b0; m_sc = 2'd2; m_fd = 4'd0;
                push_model();
            end
            pulse_tick();
            step(1);
        end
        wait_drain("fade_to_play");

        // In PLAY: ignored unlock ids, then unlock plus exit together
        set_pos(0, 0, 3'b000);
        level_clear = 1'b1; level_clear_id = 2'd3;
        step(1);
        level_clear_id = 2'd0;
        step(1);
        level_clear = 1'b0;
        step(3);
        wait_drain("ignored_ids");
        level_clear = 1'b1; level_clear_id = 2'd1; game_exit = 1'b1;
        m_unl = 3'b011; m_sel = 2'd0; m_sc = 2'd0;
        push_model();
        step(1);
        level_clear = 1'b0; level_clear_id = 2'd0; game_exit = 1'b0;
        wait_drain("unlock_exit");

        // Button 2 now unlocked: confirm it, then reset mid-fade
        set_pos(170, 210, 3'b010);
        mouse_left = 1'b1;
        step(4);
        mouse_left = 1'b0;
        m_h = 3'b000; m_sel = 2'd2; m_sc = 2'd1;
        push_model();
        step(4);
        wait_drain("confirm2");
        for (int t = 1; t <= 14; t++) begin
            if (t % 2 == 0) begin
                m_fd = 4'(t / 2);
                push_model();
            end
            pulse_tick();
        end
        wait_drain("fade_to_7");
        rst = 1'b1;
        m_h = 3'b000; m_unl = 3'b001; m_sel = 2'd0; m_st = 1'b0; m_sc = 2'd0; m_fd = 4'd0;
        push_model();
        step(2);
        rst = 1'b0;
        step(4);
        wait_drain("reset_mid_fade");
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
